// File: rtl/bi_shift_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it out LSB-first or MSB-first, one bit per shift_en cycle.
module bi_shift_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             MODE,
   input  logic             shift_en,
   output logic             Data_out,
   output logic             frame,
   output logic             last
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] sreg, sreg_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             mode_q, mode_next;
   logic             at_last;
   logic             accept;

   assign at_last    = (cnt == CNT_MAX);
   // Ready depends only on state and shift_en so the source can never loop back into it.
   assign load_ready = (state == IDLE) || (at_last && shift_en);
   assign accept     = load_valid && load_ready;

   assign frame    = (state == SHIFT);
   assign last     = frame && at_last;
   assign Data_out = frame && (mode_q ? sreg[0] : sreg[WIDTH-1]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         sreg   <= '0;
         cnt    <= '0;
         mode_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state  <= state_next;
         sreg   <= sreg_next;
         cnt    <= cnt_next;
         mode_q <= mode_next;
      end
   end

   always_comb begin
      // NOTE: hold-by-default assignments first; any path left unassigned would infer a latch.
      state_next = state;
      sreg_next  = sreg;
      cnt_next   = cnt;
      mode_next  = mode_q;

      if (accept) begin
         // Covers both a load from IDLE and a gapless reload on the final enabled bit.
         state_next = SHIFT;
         sreg_next  = load_data;
         cnt_next   = '0;
         mode_next  = MODE;
      end else if (state == SHIFT && shift_en) begin
         if (!at_last) begin
            cnt_next  = cnt + 1'b1;
            sreg_next = mode_q ? (sreg >> 1) : (sreg << 1);
         end else begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      end
   end

endmodule

// File: tb/tb_bi_shift_serializer.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic,
// compared every cycle against a queue-of-bits transmission model.
module tb_bi_shift_serializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] load_data;
   logic         load_valid;
   logic         load_ready;
   logic         MODE;
   logic         shift_en;
   logic         Data_out;
   logic         frame;
   logic         last;

   int n_checks = 0;
   int n_fails  = 0;

   bit q[$];     // bits still to appear on the line, in transmission order
   bit cap[$];   // Data_out values observed while frame is high
   bit acc;

   bi_shift_serializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .MODE       (MODE),
      .shift_en   (shift_en),
      .Data_out   (Data_out),
      .frame      (frame),
      .last       (last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_cap();
      logic [31:0] v = '0;
      for (int i = 0; i < cap.size() && i < 32; i++) v[i] = cap[i];
      return v;
   endfunction

   // One clock: compare at the falling edge, then advance the model at the rising edge.
   task automatic cycle(output bit accepted);
      bit m_ready;
      bit m_busy;
      @(negedge clk);
      m_busy  = (q.size() != 0);
      m_ready = !m_busy || (q.size() == 1 && shift_en);
      check("frame",      frame,      m_busy);
      check("data_out",   Data_out,   m_busy ? q[0] : 1'b0);
      check("last",       last,       q.size() == 1);
      check("load_ready", load_ready, m_ready);
      if (frame) cap.push_back(Data_out);
      accepted = rst && load_valid && m_ready;
      @(posedge clk);
      if (!rst) begin
         q.delete();
      end else begin
         if (m_busy && shift_en) void'(q.pop_front());
         if (accepted)
            for (int i = 0; i < W; i++) q.push_back(MODE ? load_data[i] : load_data[W-1-i]);
      end
      #1;
   endtask

   // Presents a word and waits for acceptance; load_valid is left high for the caller.
   task automatic send(input logic [W-1:0] d, input bit m);
      bit a = 1'b0;
      load_data  = d;
      MODE       = m;
      load_valid = 1'b1;
      for (int i = 0; i < 20 && !a; i++) cycle(a);
      if (!a) check("send_timeout", 0, 1);
   endtask

   task automatic run(input int n);
      bit a;
      repeat (n) cycle(a);
   endtask

   initial begin
      bit pending;

      // Reset held low with random inputs
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         load_data  = W'($urandom);
         load_valid = 1'($urandom);
         MODE       = 1'($urandom);
         shift_en   = 1'($urandom);
         cycle(acc);
      end
      load_valid = 1'b0;
      shift_en   = 1'b1;
      rst        = 1'b1;
      run(3);

      // LSB-first
      cap.delete();
      send(4'b1011, 1'b1);
      load_valid = 1'b0;
      run(6);
      check("lsb_len", cap.size(), 4);
      check("lsb_seq", pack_cap(), 32'b1011);

      // MSB-first, MODE toggled mid-word
      cap.delete();
      send(4'b1011, 1'b0);
      load_valid = 1'b0;
      MODE       = 1'b1;
      run(2);
      MODE = 1'b0;
      run(4);
      check("msb_len", cap.size(), 4);
      check("msb_seq", pack_cap(), 32'b1101);

      // Bit-rate enable: every bit held for two cycles
      cap.delete();
      send(4'b0110, 1'b1);
      load_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         shift_en = k[0];
         cycle(acc);
      end
      shift_en = 1'b1;
      run(2);
      check("en_len", cap.size(), 8);
      check("en_seq", pack_cap(), 32'h3C);

      // Back-to-back with load_valid held
      cap.delete();
      send(4'hA, 1'b1);
      send(4'h5, 1'b1);
      load_valid = 1'b0;
      run(6);
      check("b2b_len", cap.size(), 8);
      check("b2b_seq", pack_cap(), 32'h5A);

      // Asynchronous reset after the second bit
      send(4'b1111, 1'b1);
      load_valid = 1'b0;
      run(2);
      #2 rst = 1'b0;
      #1;
      check("async_frame", frame,    1'b0);
      check("async_data",  Data_out, 1'b0);
      check("async_last",  last,     1'b0);
      q.delete();
      run(2);
      rst = 1'b1;
      check("post_rst_ready", load_ready, 1'b1);
      cap.delete();
      send(4'b1000, 1'b0);
      load_valid = 1'b0;
      run(6);
      check("rst_seq", pack_cap(), 32'b0001);

      // Randomized traffic with a protocol-compliant source
      pending = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         shift_en = ($urandom_range(0, 3) != 0);
         MODE     = 1'($urandom);
         if (!pending && $urandom_range(0, 2) != 0) begin
            pending   = 1'b1;
            load_data = W'($urandom);
         end
         load_valid = pending;
         cycle(acc);
         if (acc) pending = 1'b0;
      end
      load_valid = 1'b0;
      shift_en   = 1'b1;
      run(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/bi_shift_serializer.md
# bi_shift_serializer

Parallel-in, serial-out transmitter for the team's bidirectional shift-register datapath. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle, LSB-first or MSB-first as chosen by MODE. It drives the serial line consumed by the bidirectional shift-register receiver, so a word sent here in a given MODE lands in the receiver in the same bit order. A bit counter and two-state FSM produce frame and last-bit markers and allow back-to-back words with no gap.

## Interface
- WIDTH, 4, word length in bits; legal range WIDTH >= 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  serializer can accept a word this cycle.
- MODE  input  1  bit order: 1 = LSB-first (bit 0 first), 0 = MSB-first (bit WIDTH-1 first). Sampled only at word acceptance.
- shift_en  input  1  bit-rate enable. The current bit advances only on edges where shift_en = 1.
- Data_out  output  1  serial data line.
- frame  output  1  high while Data_out carries a valid bit.
- last  output  1  high while Data_out carries the final bit of the word.

## Operation
- Internal state:
  - FSM {IDLE, SHIFT}.
  - Shift register sreg[WIDTH-1:0].
  - Latched mode bit mode_q.
  - Bit counter cnt of width clog2(WIDTH), range 0..WIDTH-1.
- Reset values (while rst = 0): state IDLE, sreg 0, cnt 0, mode_q 0, Data_out 0, frame 0, last 0. load_ready is 1 after reset, because the FSM is in IDLE.
- load_ready is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when cnt = WIDTH-1 and shift_en = 1.
  - 0 otherwise.
- Accept = load_valid & load_ready at a rising edge. On accept:
  - sreg <= load_data, mode_q <= MODE, cnt <= 0, state <= SHIFT.
- Data_out is sreg[0] when mode_q = 1 and sreg[WIDTH-1] when mode_q = 0. It is forced to 0 in IDLE.
- frame = (state == SHIFT).
- last = frame & (cnt == WIDTH-1).
- In SHIFT, on an edge with shift_en = 1:
  - If cnt < WIDTH-1: cnt <= cnt+1. If mode_q = 1, sreg shifts right (zero fill at the MSB). If mode_q = 0, sreg shifts left (zero fill at the LSB).
  - If cnt = WIDTH-1 and accept occurs: the next word loads per the accept rule, state stays SHIFT, and there is no gap cycle.
  - If cnt = WIDTH-1 and no accept: state <= IDLE, cnt <= 0.
- In SHIFT, on an edge with shift_en = 0: state, sreg and cnt hold, so the current bit is held.
- load_valid in SHIFT before the last enabled bit has no effect (load_ready = 0). The source must hold load_data and load_valid until accepted.
- MODE changes while a word is in flight are ignored; mode_q governs the whole word.
- Reset asserted mid-word: outputs clear asynchronously and the partial word is discarded. After rst rises, the block is in IDLE with load_ready = 1.

## Timing
- Latency: the first bit appears on Data_out in the cycle after the accepting edge, with frame = 1.
- Each bit persists until the first rising edge with shift_en = 1. With shift_en tied high, a word occupies exactly WIDTH cycles.
- Back-to-back words with shift_en = 1 and load_valid held: frame stays high continuously, and each word's first bit directly follows the previous word's last bit.
- Handshake is evaluated at the rising edge. load_ready depends combinationally on shift_en and state, never on load_valid.
- No combinational path from load_data or MODE to any output.

## Test plan
- Reset:
  - Stimulus: hold rst = 0 with random inputs.
  - Required: Data_out = 0, frame = 0, last = 0, load_ready = 1. After release, with no load_valid, outputs stay 0.
- LSB-first (WIDTH = 4):
  - Stimulus: MODE = 1, load 4'b1011, shift_en = 1 constant.
  - Required: Data_out = 1, 1, 0, 1 on the 4 cycles after accept; last = 1 only on the 4th cycle; frame = 0 on the 5th cycle.
- MSB-first:
  - Stimulus: MODE = 0, load 4'b1011, shift_en = 1.
  - Required: Data_out = 1, 0, 1, 1; MODE toggled mid-word does not alter this sequence.
- Bit-rate enable:
  - Stimulus: MODE = 1, load 4'b0110, shift_en high every other cycle.
  - Required: each bit 0, 1, 1, 0 is held 2 cycles; load_ready rises only in the cycle where last = 1 and shift_en = 1.
- Back-to-back:
  - Stimulus: load_valid held high with 4'hA then 4'h5, MODE = 1, shift_en = 1.
  - Required: frame high for 8 contiguous cycles; Data_out = 0, 1, 0, 1, 1, 0, 1, 0; last pulses on cycles 4 and 8.
- Reset mid-word:
  - Stimulus: rst driven low asynchronously (between clock edges) after the 2nd bit.
  - Required: frame, Data_out and last go to 0 at once, before the next clock edge. After release, load_ready = 1, and a new word 4'b1000 (MODE = 0) transmits as 1, 0, 0, 0.
